// File: rtl/response_tx_pkg.sv
// Shared types and constants for the sensor response UART transmitter.
package response_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    NEXT,
    DONE
  } state_e;

  // Scheduler response codes (6-bit, zero-extended onto the 8-bit bus)
  localparam logic [5:0] RESP_SENSOR_PROBLEM = 6'h01;
  localparam logic [5:0] RESP_HUM_TEMP       = 6'h09;
  localparam logic [5:0] RESP_SENSOR_OK      = 6'h08;
  localparam logic [5:0] RESP_MONITOR_ON     = 6'h0A;
  localparam logic [5:0] RESP_MONITOR_OFF    = 6'h0B;

  localparam logic [7:0] ADDR_SENSOR_1 = 8'h31;
  localparam logic [7:0] ADDR_SENSOR_2 = 8'h32;
  localparam logic [7:0] ADDR_SENSOR_3 = 8'h33;
  localparam logic [7:0] ADDR_SENSOR_4 = 8'h34;
  localparam logic [7:0] ADDR_SENSOR_5 = 8'h35;
  localparam logic [7:0] ADDR_SENSOR_6 = 8'h36;
  localparam logic [7:0] ADDR_SENSOR_7 = 8'h37;
  localparam logic [7:0] ADDR_SENSOR_8 = 8'h38;

endpackage

// File: rtl/response_tx_uart.sv
// uart_tx_byte: serialises one byte as 8N1, LSB first; done_c marks the last stop-bit cycle.
module uart_tx_byte
  import response_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_e           state, next;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shift, shift_d;
  logic             tx_d;
  logic             bit_end;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    next    = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next    = START;
          shift_d = data;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d = '0;
          next  = DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) next = STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d  = '0;
          done_c = 1'b1;
          next   = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: next = IDLE;
    endcase
  end

  // Line level follows the current state, so tx lags the state register by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= next;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx      <= tx_d;
    end
  end

endmodule

// File: rtl/response_tx.sv
// Sends a response frame (response, data; address first when RESPONSE_TX_ADDRESS_BYTE_EN
// is defined) over a UART line, one byte at a time through uart_tx_byte.
module response_tx
  import response_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [7:0] response_i,
  input  logic [7:0] data_i,
  input  logic [7:0] address_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef RESPONSE_TX_ADDRESS_BYTE_EN
  localparam int unsigned NBYTES = 3;
`else
  localparam int unsigned NBYTES = 2;
`endif
  localparam int unsigned IDX_W = $clog2(NBYTES + 1);

  state_e           state, next;
  logic [IDX_W-1:0] idx, idx_d;
  logic [7:0]       resp_q, data_q;
  logic [7:0]       byte_c;
  logic             latch_c, byte_start_c, byte_done_c;
  logic             busy_q, done_q;
  logic [7:0]       first_c;

`ifdef RESPONSE_TX_ADDRESS_BYTE_EN
  logic [7:0] addr_q;
  assign first_c = address_i;
`else
  logic unused_address;
  assign unused_address = ^address_i;
  assign first_c        = response_i;
`endif

  always_comb begin
    next         = state;
    idx_d        = idx;
    latch_c      = 1'b0;
    byte_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (en_i) begin
          latch_c      = 1'b1;
          byte_start_c = 1'b1;
          idx_d        = '0;
          next         = START;
        end
      end
      START: begin
        if (byte_done_c) begin
          idx_d = idx + IDX_W'(1);
          next  = NEXT;
        end
      end
      NEXT: begin
        if (idx == IDX_W'(NBYTES)) begin
          next = DONE;
        end else begin
          byte_start_c = 1'b1;
          next         = START;
        end
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // The first byte bypasses the frame buffer because it is latched on the same edge.
  always_comb begin
    byte_c = 8'h00;
    if (state == IDLE) begin
      byte_c = first_c;
    end else begin
      case (idx)
`ifdef RESPONSE_TX_ADDRESS_BYTE_EN
        IDX_W'(0): byte_c = addr_q;
        IDX_W'(1): byte_c = resp_q;
        IDX_W'(2): byte_c = data_q;
`else
        IDX_W'(0): byte_c = resp_q;
        IDX_W'(1): byte_c = data_q;
`endif
        default:   byte_c = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      resp_q <= '0;
      data_q <= '0;
`ifdef RESPONSE_TX_ADDRESS_BYTE_EN
      addr_q <= '0;
`endif
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next;
      idx    <= idx_d;
      busy_q <= (next != IDLE);
      done_q <= (state == DONE);
      if (latch_c) begin
        resp_q <= response_i;
        data_q <= data_i;
`ifdef RESPONSE_TX_ADDRESS_BYTE_EN
        addr_q <= address_i;
`endif
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start_c),
    .data  (byte_c),
    .tx    (tx_o),
    .done_c(byte_done_c)
  );

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/response_tx.md
RESPONSE_TX -- requirements
Module: response_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, meaning UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, truncated.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  start request; single-cycle pulse from the scheduler.
REQ-006 response_i  input  8  response code; the scheduler's 6-bit code arrives zero-extended.
REQ-007 data_i  input  8  sensor data byte.
REQ-008 address_i  input  8  sensor address (ASCII '1'..'8').
REQ-009 tx_o  output  1  UART serial line, 8N1, LSB first; idle level high.
REQ-010 busy_o  output  1  high from the cycle after an accepted en_i until the cycle done_o is asserted.
REQ-011 done_o  output  1  single-cycle pulse signalling that the frame has been completely transmitted.

Function
REQ-012 When en_i is sampled high in IDLE, the block SHALL latch response_i, data_i and address_i into a frame buffer in the same edge and leave IDLE.
REQ-013 When en_i is sampled high while busy_o=1, the block SHALL ignore it, with no relatch and no queueing.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, NEXT and DONE.
REQ-015 IDLE->START on accept. START drives tx_o=0 for CLKS_PER_BIT cycles, then ->DATA.
REQ-016 DATA SHALL shift 8 bits LSB first, each held CLKS_PER_BIT cycles, using a 3-bit bit index, then ->STOP.
REQ-017 STOP drives tx_o=1 for CLKS_PER_BIT cycles, then ->NEXT.
REQ-018 NEXT SHALL advance the byte index: if bytes remain ->START, else ->DONE.
REQ-019 DONE SHALL assert done_o for exactly one cycle, then ->IDLE; busy_o SHALL be 0 in that same cycle.
REQ-020 Byte order SHALL be response, then data; with ADDRESS_BYTE_EN the order SHALL be address, response, data.
REQ-021 There SHALL be no idle gap between bytes beyond the single NEXT cycle.
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT-1, SHALL reset to 0 at every bit boundary, and SHALL never wrap mid-bit.
REQ-023 Latency from the accepting edge to the first falling edge of tx_o SHALL be 1 cycle.
REQ-024 Latency from the accepting edge to done_o SHALL be N*(10*CLKS_PER_BIT+1)+1 cycles, where N is the byte count.
REQ-025 tx_o SHALL be register-driven and glitch-free.

Reset
REQ-026 While rst_n=0, outputs SHALL be tx_o=1, busy_o=0 and done_o=0, with the FSM in IDLE and all counters and the frame buffer at 0.
REQ-027 Reset asserted mid-frame SHALL force tx_o high immediately (asynchronously) and SHALL abort the frame with no done_o.
REQ-028 After rst_n deasserts, the first en_i SHALL be accepted normally.

Configuration
REQ-029 Macro RESPONSE_TX_ADDRESS_BYTE_EN defined: the frame SHALL be 3 bytes (address, response, data) and the byte index SHALL be 2 bits.
REQ-030 Macro RESPONSE_TX_ADDRESS_BYTE_EN undefined: the frame SHALL be 2 bytes, address_i SHALL be unused, and no address register SHALL be synthesised.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state enum;
- the response code constants;
- the ASCII sensor address constants '1'..'8'.
REQ-032 Response code constants SHALL include: sensor problem, humidity and temperature measurement, sensor OK, and continuous-monitoring enabled/disabled.
REQ-033 One sub-module, uart_tx_byte, SHALL serialise a single byte with a start/done handshake; response_tx SHALL sequence the bytes around it.

Verification (CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10)
REQ-034 Scenario, 2-byte frame:
- stimulus: en_i pulse with response_i=0x09, data_i=0x1A;
- response: tx_o carries 0x09 then 0x1A, LSB first, 10 cycles per bit;
- response: done_o pulses at cycle 203 after accept.
REQ-035 Scenario, en_i while busy:
- stimulus: second en_i pulse at cycle 50 with data_i=0xFF;
- response: the frame is unchanged and only one done_o pulse occurs.
REQ-036 Scenario, back-to-back frames:
- stimulus: en_i in the cycle after done_o;
- response: the second frame is accepted and START begins 1 cycle later.
REQ-037 Scenario, reset mid-frame:
- stimulus: rst_n=0 at cycle 37 for 3 cycles;
- response: tx_o goes high immediately and busy_o=0;
- response: no done_o occurs, and a subsequent frame transmits correctly.
REQ-038 Scenario, RESPONSE_TX_ADDRESS_BYTE_EN defined:
- stimulus: address_i=0x31, response_i=0x08, data_i=0x19;
- response: three bytes transmitted in the order 0x31, 0x08, 0x19;
- response: done_o at cycle 304.
